// File: rtl/gray_conv_pipe.sv
// gray_conv_pipe
// Streaming Gray/binary converter. Each sample carries its own direction bit.
// Gray-to-binary splits the MSB-first XOR chain across STAGES registers, so
// each stage only resolves about WIDTH/STAGES bits. Binary-to-Gray finishes in
// stage 1 and then rides through the remaining stages, so both directions
// have the same latency.
// A single-step checker looks at successive Gray inputs and flags any sample
// that differs from the previous Gray input in more than one bit. The flag
// travels with the sample. A saturating counter totals flagged samples as
// they leave the converter.
// The whole pipeline shifts only when the output slot is empty or is being
// consumed. There is no bubble collapsing.
module gray_conv_pipe #(
    parameter int WIDTH         = 8,
    parameter int STAGES        = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_mode,
    output logic                     out_step_err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    input  logic                     err_clr
);

    // Number of Gray bits resolved per stage (the last stages may resolve fewer or none)
    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    if (WIDTH < 2) begin : g_bad_width
        $error("gray_conv_pipe: WIDTH must be at least 2");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("gray_conv_pipe: STAGES must lie in 1..WIDTH");
    end
    if (ERR_CNT_WIDTH < 1) begin : g_bad_cnt
        $error("gray_conv_pipe: ERR_CNT_WIDTH must be at least 1");
    end

    // Resolve the slice of the Gray-to-binary chain owned by stage k (1-based).
    // Bits above the slice are already binary. The slice is resolved MSB first,
    // so each bit XORs with the binary bit just above it. Bits below the slice
    // are still Gray and pass through unchanged.
    function automatic logic [WIDTH-1:0] g2b_stage(input logic [WIDTH-1:0] v, input int k);
        logic [WIDTH-1:0] r;
        int               hi;
        int               lo;
        r  = v;
        hi = WIDTH - 1 - (k - 1) * CHUNK;
        lo = WIDTH - k * CHUNK;
        if (lo < 0) begin
            lo = 0;
        end
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                r[i] = r[i+1] ^ v[i];
            end
        end
        return r;
    endfunction

    // Binary to reflected Gray code in one step
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // True when the two codes differ in more than one bit position
    function automatic logic multi_bit_step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        int               n;
        x = a ^ b;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                n++;
            end
        end
        return n > 1;
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                           advance;
    logic                           in_fire;
    logic                           in_step_err;

    logic [STAGES-1:0]              vld_q;
    logic [STAGES-1:0]              vld_d;
    logic [STAGES-1:0]              mode_q;
    logic [STAGES-1:0]              mode_d;
    logic [STAGES-1:0]              serr_q;
    logic [STAGES-1:0]              serr_d;
    logic [STAGES-1:0][WIDTH-1:0]   data_q;
    logic [STAGES-1:0][WIDTH-1:0]   data_d;

    logic [WIDTH-1:0]               prev_gray_q;
    logic [WIDTH-1:0]               prev_gray_d;
    logic                           prev_vld_q;
    logic                           prev_vld_d;

    logic [ERR_CNT_WIDTH-1:0]       err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0]       err_cnt_d;

    assign out_valid    = vld_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign out_mode     = mode_q[STAGES-1];
    assign out_step_err = serr_q[STAGES-1];
    assign err_cnt      = err_cnt_q;

    // Global shift enable: the output slot is free or is being drained this cycle
    always_comb begin
        advance  = !out_valid || out_ready;
        in_ready = advance;
        in_fire  = in_valid && advance;
    end

    // Single-step check against the last accepted Gray input. Binary-mode samples are ignored.
    always_comb begin
        prev_gray_d = prev_gray_q;
        prev_vld_d  = prev_vld_q;
        in_step_err = !in_mode && prev_vld_q && multi_bit_step(in_data, prev_gray_q);
        if (in_fire && !in_mode) begin
            prev_gray_d = in_data;
            prev_vld_d  = 1'b1;
        end
    end

    // Next state of every pipeline stage. Everything holds unless advance is high.
    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        serr_d = serr_q;
        data_d = data_q;
        if (advance) begin
            vld_d[0]  = in_valid;
            mode_d[0] = in_mode;
            serr_d[0] = in_step_err;
            data_d[0] = in_mode ? bin_to_gray(in_data) : g2b_stage(in_data, 1);
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                mode_d[s] = mode_q[s-1];
                serr_d[s] = serr_q[s-1];
                data_d[s] = mode_q[s-1] ? data_q[s-1] : g2b_stage(data_q[s-1], s + 1);
            end
        end
    end

    // Error counter: clear wins over an increment in the same cycle
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (out_valid && out_ready && out_step_err) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    // Pipeline registers. Reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            mode_q <= '0;
            serr_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            serr_q <= serr_d;
            data_q <= data_d;
        end
    end

    // Gray history register used by the single-step check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray_q <= '0;
            prev_vld_q  <= 1'b0;
        end else begin
            prev_gray_q <= prev_gray_d;
            prev_vld_q  <= prev_vld_d;
        end
    end

    // Saturating step-error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
